// File: rtl/pixel_arb_pkg.sv
// Shared types for the two-source pixel stream arbiter.
package pixel_arb_pkg;

    localparam int NUM_SRC = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } arb_state_t;

    typedef logic src_id_t;

    // The header carries the source ID in bit 0, so that bit of the base is discarded.
    function automatic logic [7:0] hdrByte(input logic [7:0] base, input src_id_t id);
        return (base & 8'hFE) | {7'b0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the source
// that did not own the previous frame.
module rr_arbiter2
    import pixel_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  src_id_t            last_grant_i,
    output src_id_t            winner_o,
    output logic               valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = last_grant_i;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = last_grant_i;
        endcase
    end

endmodule

// File: rtl/pixel_stream_arbiter.sv
// Frames pixels from two sources onto one byte link: header with source ID,
// FRAME_LEN payload bytes, padding if the owning source stalls too long.
module pixel_stream_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter logic [7:0] HDR_BASE  = 8'hA0,
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         TIMEOUT   = 255
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       src0_valid,
    input  logic [7:0] src0_pixel,
    output logic       src0_ready,
    input  logic       src1_valid,
    input  logic [7:0] src1_pixel,
    output logic       src1_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       grant,
    output logic       busy,
    output logic       pad_event
);

    localparam int PW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT);

    arb_state_t    state_q;
    src_id_t       grant_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          out_last_q;
    logic [PW-1:0] pix_cnt_q;
    logic [PW-1:0] pix_cnt_d;
    logic [IW-1:0] idle_cnt_q;
    logic [IW-1:0] idle_cnt_d;
    logic          pad_event_q;

    logic          can_load;
    logic          sel_valid;
    logic [7:0]    sel_pixel;
    logic          pay_ready;
    logic          accept;
    logic          is_last;
    src_id_t       arb_winner;
    logic          arb_valid;

    rr_arbiter2 u_rr (
        .req_i        ({src1_valid, src0_valid}),
        .last_grant_i (grant_q),
        .winner_o     (arb_winner),
        .valid_o      (arb_valid)
    );

    assign can_load   = !out_valid_q || out_ready;
    assign sel_valid  = grant_q ? src1_valid : src0_valid;
    assign sel_pixel  = grant_q ? src1_pixel : src0_pixel;
    // Reset gating keeps a source from believing a pixel was taken during reset.
    assign pay_ready  = reset && (state_q == ST_PAYLOAD) && can_load;
    assign src0_ready = pay_ready && !grant_q;
    assign src1_ready = pay_ready && grant_q;
    assign accept     = pay_ready && sel_valid;
    assign is_last    = (pix_cnt_q == LAST_IDX);
    assign pix_cnt_d  = pix_cnt_q + 1'b1;
    assign idle_cnt_d = idle_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            pix_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            pad_event_q <= 1'b0;
        end else begin
            pad_event_q <= 1'b0;
            if (can_load) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_winner;
                        state_q <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (can_load) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= hdrByte(HDR_BASE, grant_q);
                        out_last_q  <= 1'b0;
                        pix_cnt_q   <= '0;
                        idle_cnt_q  <= '0;
                        state_q     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= sel_pixel;
                        out_last_q  <= is_last;
                        pix_cnt_q   <= pix_cnt_d;
                        idle_cnt_q  <= '0;
                        if (is_last) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (can_load) begin
                        // Only cycles where the link could take a byte count as starvation.
                        idle_cnt_q <= idle_cnt_d;
                        if (idle_cnt_d == IDLE_LIM) begin
                            state_q     <= ST_PAD;
                            pad_event_q <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (can_load) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= PAD_BYTE;
                        out_last_q  <= is_last;
                        pix_cnt_q   <= pix_cnt_d;
                        if (is_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign pad_event = pad_event_q;

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Scoreboard bench for pixel_stream_arbiter: stimulus pushes expected link bytes,
// a negedge monitor pops and compares every byte the link accepts.
module tb_pixel_stream_arbiter;
    import pixel_arb_pkg::*;

    localparam int FRAME_LEN = 16;
    localparam int TIMEOUT   = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       isHdr;
    } exp_t;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       src0_valid = 1'b0;
    logic [7:0] src0_pixel = 8'h00;
    logic       src1_valid = 1'b0;
    logic [7:0] src1_pixel = 8'h00;
    logic       out_ready  = 1'b1;
    logic       src0_ready;
    logic       src1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       grant;
    logic       busy;
    logic       pad_event;

    exp_t       expQ[$];
    logic [7:0] pix0Q[$];
    logic [7:0] pix1Q[$];

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   hdrCyc   = 0;
    int   lastCyc  = 0;
    int   padCount = 0;
    bit   inPad    = 1'b0;
    bit   en0      = 1'b0;
    bit   en1      = 1'b0;
    bit   tog0     = 1'b0;
    bit   rndReady = 1'b0;
    logic readyLevel = 1'b1;

    pixel_stream_arbiter #(
        .FRAME_LEN (FRAME_LEN),
        .HDR_BASE  (8'hA0),
        .PAD_BYTE  (8'h00),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src0_valid (src0_valid),
        .src0_pixel (src0_pixel),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_pixel (src1_pixel),
        .src1_ready (src1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .grant      (grant),
        .busy       (busy),
        .pad_event  (pad_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input logic [7:0] data, input logic last, input logic isHdr);
        exp_t e;
        e.data  = data;
        e.last  = last;
        e.isHdr = isHdr;
        expQ.push_back(e);
    endtask

    // Queue one frame: nSend real pixels from source src, then nPad pad bytes expected.
    task automatic applyStimulus(input int src, input logic [7:0] first, input logic [7:0] step,
                                 input int nSend, input int nPad);
        logic [7:0] px;
        pushExp(8'hA0 | 8'(src), 1'b0, 1'b1);
        px = first;
        for (int i = 0; i < nSend; i++) begin
            if (src == 0) pix0Q.push_back(px);
            else          pix1Q.push_back(px);
            pushExp(px, (i == FRAME_LEN - 1), 1'b0);
            px = px + step;
        end
        for (int i = nSend; i < nSend + nPad; i++) begin
            pushExp(8'h00, (i == FRAME_LEN - 1), 1'b0);
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 600) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: drain timeout, %0d bytes outstanding, expected 0", name, expQ.size());
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Source/link driver: samples handshakes at negedge, updates inputs just after posedge.
    initial begin : driver
        bit acc0;
        bit acc1;
        forever begin
            @(negedge clk);
            acc0 = src0_valid && src0_ready;
            acc1 = src1_valid && src1_ready;
            @(posedge clk);
            #1;
            if (acc0 && pix0Q.size() > 0) void'(pix0Q.pop_front());
            if (acc1 && pix1Q.size() > 0) void'(pix1Q.pop_front());
            src0_valid = en0 && (pix0Q.size() > 0) && !(tog0 && acc0);
            src0_pixel = (pix0Q.size() > 0) ? pix0Q[0] : 8'h00;
            src1_valid = en1 && (pix1Q.size() > 0);
            src1_pixel = (pix1Q.size() > 0) ? pix1Q[0] : 8'h00;
            out_ready  = rndReady ? 1'($urandom_range(1, 0)) : readyLevel;
        end
    end

    // Monitor: pops the scoreboard on every link transfer and watches ready exclusivity.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (busy) checkOutput("readyExclusive", int'(src0_ready && src1_ready), 0);
            if (pad_event) begin
                padCount++;
                inPad = 1'b1;
            end
            if (inPad) checkOutput("padReadyLow", int'(src0_ready || src1_ready), 0);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedByte: got 0x%0h, expected no byte (cycle %0d)", out_data, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outData", int'(out_data), int'(e.data));
                    checkOutput("outLast", int'(out_last), int'(e.last));
                    if (e.isHdr) hdrCyc = cyc;
                    if (e.last)  lastCyc = cyc;
                end
                if (out_last) inPad = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int n;
        int k;
        int padBefore;

        // Reset values
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstOutData", int'(out_data), 0);
        checkOutput("rstOutLast", int'(out_last), 0);
        checkOutput("rstGrant", int'(grant), 1);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstPadEvent", int'(pad_event), 0);
        checkOutput("rstSrc0Ready", int'(src0_ready), 0);
        checkOutput("rstSrc1Ready", int'(src1_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #2;

        // 1: src0 alone, continuous, link always ready
        applyStimulus(0, 8'h00, 8'h11, 16, 0);
        en0 = 1'b1;
        waitDrain("t1Drain");
        en0 = 1'b0;
        checkOutput("t1Grant", int'(grant), 0);
        checkOutput("t1FrameSpan", lastCyc - hdrCyc, 16);

        // 2: both sources valid from reset, frames must alternate starting with src0
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(0, 8'h10, 8'h01, 16, 0);
        applyStimulus(1, 8'h80, 8'h01, 16, 0);
        applyStimulus(0, 8'h20, 8'h01, 16, 0);
        applyStimulus(1, 8'h90, 8'h01, 16, 0);
        en0 = 1'b1;
        en1 = 1'b1;
        waitDrain("t2Drain");
        en0 = 1'b0;
        en1 = 1'b0;

        // 3: src0 drops valid after every accepted pixel, link ready random
        tog0     = 1'b1;
        rndReady = 1'b1;
        applyStimulus(0, 8'h30, 8'h03, 16, 0);
        en0 = 1'b1;
        waitDrain("t3Drain");
        en0      = 1'b0;
        tog0     = 1'b0;
        rndReady = 1'b0;
        readyLevel = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 4: src1 sends three pixels then starves, the frame is padded
        padBefore = padCount;
        applyStimulus(1, 8'hC1, 8'h01, 3, 13);
        en1 = 1'b1;
        n = 0;
        while (pix1Q.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!pad_event && k < 20);
        checkOutput("t4PadLatency", k, TIMEOUT);
        waitDrain("t4Drain");
        en1 = 1'b0;
        checkOutput("t4PadPulses", padCount - padBefore, 1);
        checkOutput("t4Grant", int'(grant), 1);

        // 5: reset while the eighth pixel (index 7) is being formed
        pushExp(8'hA0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) pushExp(8'h50 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) pix0Q.push_back(8'h50 + 8'(i));
        en0 = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t5ReachedPix7", expQ.size(), 0);
        reset = 1'b0;
        en0   = 1'b0;
        pix0Q.delete();
        expQ.delete();
        @(posedge clk);
        #2;
        checkOutput("t5OutValid", int'(out_valid), 0);
        checkOutput("t5Busy", int'(busy), 0);
        checkOutput("t5Grant", int'(grant), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(0, 8'h60, 8'h01, 16, 0);
        en0 = 1'b1;
        waitDrain("t5Drain");
        en0 = 1'b0;

        // 6: link stalls on the header while the source goes quiet; no padding may start
        padBefore  = padCount;
        readyLevel = 1'b0;
        applyStimulus(1, 8'h70, 8'h01, 16, 0);
        en1 = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        en1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            checkOutput("t6HdrHeld", int'(out_data), 8'hA1);
            checkOutput("t6ValidHeld", int'(out_valid), 1);
            checkOutput("t6NoAccept", int'(src1_ready), 0);
        end
        en1        = 1'b1;
        readyLevel = 1'b1;
        waitDrain("t6Drain");
        en1 = 1'b0;
        checkOutput("t6NoPad", padCount - padBefore, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
